// File: rtl/fb_access_arbiter_if.sv
// Signal bundle between the frame-buffer arbiter, its camera/PC/edge-pipeline clients and the memory.
// drop_cnt is present only when FB_ARB_DROP_CNT_EN is defined.
interface fb_access_arbiter_if #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 16
);
  logic                  src_sel;
  logic                  cam_we;
  logic [ADDR_WIDTH-1:0] cam_waddr;
  logic [DATA_WIDTH-1:0] cam_wdata;
  logic                  pc_we;
  logic [ADDR_WIDTH-1:0] pc_waddr;
  logic [DATA_WIDTH-1:0] pc_wdata;
  logic                  rd_req;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic                  rd_gnt;
  logic                  rd_valid;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  frame_release;
  logic                  fb_en;
  logic                  fb_we;
  logic [ADDR_WIDTH-1:0] fb_addr;
  logic [DATA_WIDTH-1:0] fb_wdata;
  logic [DATA_WIDTH-1:0] fb_rdata;
  logic                  frame_done;
  logic                  busy;
`ifdef FB_ARB_DROP_CNT_EN
  logic [15:0]           drop_cnt;
`endif

  modport slave (
`ifdef FB_ARB_DROP_CNT_EN
    output drop_cnt,
`endif
    input  src_sel, cam_we, cam_waddr, cam_wdata, pc_we, pc_waddr, pc_wdata,
    input  rd_req, rd_addr, frame_release, fb_rdata,
    output rd_gnt, rd_valid, rd_data, fb_en, fb_we, fb_addr, fb_wdata, frame_done, busy
  );

  modport master (
`ifdef FB_ARB_DROP_CNT_EN
    input  drop_cnt,
`endif
    output src_sel, cam_we, cam_waddr, cam_wdata, pc_we, pc_waddr, pc_wdata,
    output rd_req, rd_addr, frame_release, fb_rdata,
    input  rd_gnt, rd_valid, rd_data, fb_en, fb_we, fb_addr, fb_wdata, frame_done, busy
  );
endinterface

// File: rtl/fb_access_arbiter.sv
// Single-port frame-buffer arbiter: buffers camera or PC pixel writes, interleaves pipeline reads,
// and locks the frame once fully written. Define FB_ARB_DROP_CNT_EN to add the drop_cnt counter.
module fb_access_arbiter #(
  parameter int IMG_WIDTH  = 176,
  parameter int IMG_HEIGHT = 240,
  parameter int ADDR_WIDTH = $clog2(IMG_WIDTH * IMG_HEIGHT),
  parameter int DATA_WIDTH = 16
) (
  input logic                clk,
  input logic                reset,
  fb_access_arbiter_if.slave bus
);
  localparam int                   CNT_WIDTH    = ADDR_WIDTH + 1;
  localparam logic [CNT_WIDTH-1:0] FRAME_PIXELS = CNT_WIDTH'(IMG_WIDTH * IMG_HEIGHT);

  typedef enum logic [1:0] {IDLE, FILL, READY} state_e;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data;
  } wr_entry_t;

  state_e               state_q, state_d;
  logic                 src_q, src_d;
  wr_entry_t [1:0]      buf_q, buf_d;
  logic [1:0]           fill_q, fill_d;
  logic [CNT_WIDTH-1:0] wcnt_q, wcnt_d;
  logic                 rd_valid_q;

  logic      sel_pc, cam_acc, pc_acc, wr_acc;
  logic      do_write, do_read, frame_done, rd_valid;
  wr_entry_t wr_new;

  // In IDLE the live src_sel picks the source so the very first strobe of a frame is honoured.
  always_comb begin
    sel_pc  = (state_q == IDLE) ? bus.src_sel : src_q;
    cam_acc = !reset && (state_q != READY) && !sel_pc && bus.cam_we;
    pc_acc  = !reset && (state_q != READY) &&  sel_pc && bus.pc_we;
    wr_acc  = cam_acc || pc_acc;
    if (pc_acc) begin
      wr_new.addr = bus.pc_waddr;
      wr_new.data = bus.pc_wdata;
    end else begin
      wr_new.addr = bus.cam_waddr;
      wr_new.data = bus.cam_wdata;
    end
    // A full buffer must drain now, otherwise the next accepted write would have nowhere to go.
    do_write = !reset && ((fill_q == 2'd2) || (!bus.rd_req && (fill_q != 2'd0)));
    do_read  = !reset && bus.rd_req && (fill_q != 2'd2);
  end

  // NOTE: every signal driven in a combinational block gets a default first, so no path infers a latch.
  always_comb begin
    buf_d  = buf_q;
    fill_d = fill_q;
    if (do_write) begin
      buf_d[0] = buf_q[1];
      fill_d   = fill_q - 2'd1;
    end
    if (wr_acc) begin
      buf_d[fill_d[0]] = wr_new;
      fill_d           = fill_d + 2'd1;
    end
  end

  always_comb begin
    state_d    = state_q;
    src_d      = src_q;
    wcnt_d     = wcnt_q + CNT_WIDTH'(do_write);
    frame_done = 1'b0;
    unique case (state_q)
      IDLE: begin
        src_d = bus.src_sel;
        if (wr_acc) state_d = FILL;
      end
      FILL: begin
        if ((wcnt_q >= FRAME_PIXELS) && (fill_q == 2'd0)) begin
          state_d    = READY;
          frame_done = 1'b1;
        end
      end
      READY: begin
        if (bus.frame_release) begin
          state_d = IDLE;
          wcnt_d  = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      src_q      <= 1'b0;
      fill_q     <= 2'd0;
      wcnt_q     <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      src_q      <= src_d;
      fill_q     <= fill_d;
      wcnt_q     <= wcnt_d;
      rd_valid_q <= do_read;
    end
  end

  // NOTE: the buffer payload is left unreset; fill_q alone says which entries are live.
  always_ff @(posedge clk) begin
    buf_q <= buf_d;
  end

  assign rd_valid       = rd_valid_q && !reset;
  assign bus.rd_gnt     = do_read;
  assign bus.rd_valid   = rd_valid;
  assign bus.rd_data    = rd_valid ? bus.fb_rdata : '0;
  assign bus.fb_en      = do_write || do_read;
  assign bus.fb_we      = do_write;
  assign bus.fb_addr    = do_write ? buf_q[0].addr : (do_read ? bus.rd_addr : '0);
  assign bus.fb_wdata   = do_write ? buf_q[0].data : '0;
  assign bus.frame_done = frame_done && !reset;
  assign bus.busy       = (state_q == FILL) && !reset;

`ifdef FB_ARB_DROP_CNT_EN
  logic [15:0] drop_q, drop_d;
  logic [16:0] drop_sum;

  always_comb begin
    drop_sum = {1'b0, drop_q} + 17'(bus.cam_we && !cam_acc) + 17'(bus.pc_we && !pc_acc);
    drop_d   = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    if ((state_q == READY) && bus.frame_release) drop_d = '0;
  end

  always_ff @(posedge clk) begin
    if (reset) drop_q <= '0;
    else       drop_q <= drop_d;
  end

  assign bus.drop_cnt = drop_q;
`endif
endmodule
